// File: rtl/rsdec_berl_ctrl_if.sv
// ----------------------------------------------------------------------------
// rsdec_berl_ctrl_if
//
// Purpose:
//   Handshake bundle between the Berlekamp sequencer and its neighbours.
//   The syndrome stage upstream raises start (with syn_zero), and the
//   Chien/Forney stage downstream watches done and returns ack.
//
// Signals:
//   start     syndromes valid (upstream -> sequencer)
//   syn_zero  all syndromes zero, qualified by start (upstream -> sequencer)
//   ack       result accepted (downstream -> sequencer)
//   busy      sequencer not idle (sequencer -> neighbours)
//   done      coefficients valid, datapath frozen (sequencer -> downstream)
//
// Modports:
//   master    environment side: drives start/syn_zero/ack
//   slave     sequencer side: drives busy/done
// ----------------------------------------------------------------------------
interface rsdec_berl_ctrl_if;
    logic start;
    logic syn_zero;
    logic ack;
    logic busy;
    logic done;

    modport master (
        output start,
        output syn_zero,
        output ack,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  syn_zero,
        input  ack,
        output busy,
        output done
    );
endinterface

// File: rtl/rsdec_berl_ctrl.sv
// ----------------------------------------------------------------------------
// rsdec_berl_ctrl
//
// Purpose:
//   Sequencer for the Berlekamp key-equation datapath (rsdec_berl) of the
//   RS(255,223) decoder. Each of the NITER iterations takes NSLOT cycles:
//   one phase0 slot (discrepancy compute) followed by 32 shift slots, the
//   last of which is flagged by phase32. While an iteration runs, the
//   discrepancy D latched by the datapath is inverted serially over
//   GF(2^8) (x^8+x^4+x^3+x^2+1) as D^254 and presented on DI from slot 15
//   onward, ready for the next iteration's phase0.
//
// Ports:
//   clk      clock
//   clrn     asynchronous active-low reset
//   bus      handshake interface (slave): start, syn_zero, ack in;
//            busy, done out
//   D        discrepancy from the datapath
//   DI       D^-1 to the datapath
//   count    iteration index 0..NITER-1 (6'h3F while holding)
//   phase0   slot 0 of an iteration
//   phase32  slot 32 of an iteration
//   enable   low = datapath initialise
//
// Build option:
//   RSDEC_BERL_CTRL_SKIP_EN  when defined, a start with syn_zero=1 bypasses
//                            the iterations and goes straight to HOLD with
//                            the datapath left at its initial values.
// ----------------------------------------------------------------------------
module rsdec_berl_ctrl #(
    parameter int NITER = 32
) (
    input  logic                 clk,
    input  logic                 clrn,
    rsdec_berl_ctrl_if.slave     bus,
    input  logic [7:0]           D,
    output logic [7:0]           DI,
    output logic [5:0]           count,
    output logic                 phase0,
    output logic                 phase32,
    output logic                 enable
);

    localparam int NSLOT = NITER + 1;

    localparam logic [5:0] SLOT_LAST  = 6'(NSLOT - 1);
    localparam logic [5:0] SLOT_PRE   = 6'(NSLOT - 2);
    localparam logic [5:0] COUNT_LAST = 6'(NITER - 1);
    localparam logic [5:0] COUNT_HOLD = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SKIP,
        ST_HOLD
    } state_t;

    state_t     state;
    logic [5:0] slot;
    logic       busy;
    logic       done;

    logic [7:0] dq;
    logic [7:0] acc;
    logic [7:0] prod;
    logic [7:0] mul_b;

    assign bus.busy = busy;
    assign bus.done = done;

`ifndef RSDEC_BERL_CTRL_SKIP_EN
    // syn_zero only matters when the skip path is built in.
    logic unused_syn_zero;
    assign unused_syn_zero = bus.syn_zero;
`endif

    // GF(2^8) multiply, field polynomial 0x11D (same as the datapath).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Sequencer FSM. All datapath controls are registered here so they
    // change cleanly on the clock edge. phase32 is set one slot early
    // (from SLOT_PRE) so that it is high exactly while slot==32. In HOLD the
    // datapath sees phase0=1 with count=3F, which freezes its shift
    // registers and suppresses the L update.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_IDLE;
            slot    <= 6'd0;
            count   <= 6'd0;
            phase0  <= 1'b0;
            phase32 <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
`ifdef RSDEC_BERL_CTRL_SKIP_EN
                        if (bus.syn_zero) begin
                            // enable stays low for this one cycle so the
                            // datapath settles at lambda=1, omega=1.
                            state <= ST_SKIP;
                            busy  <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            slot    <= 6'd0;
                            count   <= 6'd0;
                            phase0  <= 1'b1;
                            phase32 <= 1'b0;
                            enable  <= 1'b1;
                            busy    <= 1'b1;
                        end
`else
                        state   <= ST_RUN;
                        slot    <= 6'd0;
                        count   <= 6'd0;
                        phase0  <= 1'b1;
                        phase32 <= 1'b0;
                        enable  <= 1'b1;
                        busy    <= 1'b1;
`endif
                    end
                end

                ST_RUN: begin
                    if (slot == SLOT_LAST) begin
                        slot    <= 6'd0;
                        phase0  <= 1'b1;
                        phase32 <= 1'b0;
                        if (count == COUNT_LAST) begin
                            state <= ST_HOLD;
                            count <= COUNT_HOLD;
                            done  <= 1'b1;
                        end else begin
                            count <= count + 6'd1;
                        end
                    end else begin
                        slot    <= slot + 6'd1;
                        phase0  <= 1'b0;
                        phase32 <= (slot == SLOT_PRE);
                    end
                end

                ST_SKIP: begin
                    state   <= ST_HOLD;
                    slot    <= 6'd0;
                    count   <= COUNT_HOLD;
                    phase0  <= 1'b1;
                    phase32 <= 1'b0;
                    enable  <= 1'b1;
                    done    <= 1'b1;
                end

                ST_HOLD: begin
                    if (bus.ack) begin
                        state   <= ST_IDLE;
                        slot    <= 6'd0;
                        count   <= 6'd0;
                        phase0  <= 1'b0;
                        phase32 <= 1'b0;
                        enable  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    slot    <= 6'd0;
                    count   <= 6'd0;
                    phase0  <= 1'b0;
                    phase32 <= 1'b0;
                    enable  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Single shared multiplier. The exponent chain for D^254 alternates
    // square (even slots) and multiply-by-Dq (odd slots):
    //   D^2, D^3, D^6, D^7, ... , D^127, D^254  (13 products, slots 2..14).
    always_comb begin
        mul_b = slot[0] ? dq : acc;
        prod  = gf_mul(acc, mul_b);
    end

    // Serial inverter. D is registered by the datapath at phase0, so it is
    // valid during slot 1 and is captured at the end of that slot. The last
    // product lands directly in DI, making DI change at the start of slot 15
    // and stay put through phase0 of the next iteration. Zero stays zero
    // through the chain, giving DI=0 for D=0. Starting a run reloads DI=1
    // for iteration 0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            DI  <= 8'h01;
            dq  <= 8'h00;
            acc <= 8'h00;
        end else if (state == ST_IDLE) begin
            if (bus.start) begin
                DI <= 8'h01;
            end
        end else if (state == ST_RUN) begin
            if (slot == 6'd1) begin
                dq  <= D;
                acc <= D;
            end else if (slot >= 6'd2 && slot <= 6'd13) begin
                acc <= prod;
            end else if (slot == 6'd14) begin
                DI <= prod;
            end
        end
    end

endmodule

// File: tb/tb_rsdec_berl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rsdec_berl_ctrl
//
// Purpose:
//   Directed self-checking bench for rsdec_berl_ctrl. The bench plays the
//   datapath (drives D at each phase0) and the neighbouring stages (start,
//   ack). Every D driven pushes its field inverse onto a queue; the entry
//   is popped and becomes the expected DI at slot 15 of that iteration.
//
// Ports: none (top-level bench). Honours RSDEC_BERL_CTRL_SKIP_EN to add
// the syndrome-zero bypass steps.
// ----------------------------------------------------------------------------
module tb_rsdec_berl_ctrl;

    logic       clk;
    logic       clrn;
    logic [7:0] D;
    logic [7:0] DI;
    logic [5:0] count;
    logic       phase0;
    logic       phase32;
    logic       enable;

    rsdec_berl_ctrl_if bus ();

    rsdec_berl_ctrl #(.NITER(32)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .bus     (bus),
        .D       (D),
        .DI      (DI),
        .count   (count),
        .phase0  (phase0),
        .phase32 (phase32),
        .enable  (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] di_cur;
    logic [7:0] di_q[$];

    // Reference field multiply, polynomial 0x11D.
    function automatic logic [7:0] gf_mul_model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        for (int i = 7; i >= 0; i--) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h11D;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[7:0];
    endfunction

    // Inverse by exhaustive search; zero maps to zero.
    function automatic logic [7:0] inv_model(input logic [7:0] d);
        logic [7:0] x;
        if (d == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++) begin
            x = 8'(i);
            if (gf_mul_model(d, x) == 8'h01) return x;
        end
        return 8'h00;
    endfunction

    // Discrepancy the bench presents for a given iteration.
    function automatic logic [7:0] d_for(input int iter);
        case (iter)
            3:       return 8'h02;
            5:       return 8'h00;
            6:       return 8'h01;
            default: return 8'($urandom_range(2, 255));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_enable"},  32'(enable),   32'd0);
        check_output({tag, "_phase0"},  32'(phase0),   32'd0);
        check_output({tag, "_phase32"}, 32'(phase32),  32'd0);
        check_output({tag, "_count"},   32'(count),    32'd0);
        check_output({tag, "_DI"},      32'(DI),       32'h01);
        check_output({tag, "_busy"},    32'(bus.busy), 32'd0);
        check_output({tag, "_done"},    32'(bus.done), 32'd0);
    endtask

    task automatic check_hold(input string tag);
        check_output({tag, "_done"},    32'(bus.done), 32'd1);
        check_output({tag, "_phase0"},  32'(phase0),   32'd1);
        check_output({tag, "_enable"},  32'(enable),   32'd1);
        check_output({tag, "_count"},   32'(count),    32'h3F);
        check_output({tag, "_phase32"}, 32'(phase32),  32'd0);
        check_output({tag, "_busy"},    32'(bus.busy), 32'd1);
        check_output({tag, "_DI"},      32'(DI),       32'(di_cur));
    endtask

    // Drive a one-cycle start (cycle 0 of a run).
    task automatic apply_stimulus_start();
        bus.start    = 1'b1;
        bus.syn_zero = 1'b0;
        cyc          = 0;
        di_cur       = 8'h01;
        di_q.delete();
    endtask

    // Advance one RUN cycle and check every datapath control against the
    // slot/iteration implied by the cycle number since start.
    task automatic run_cycle();
        int slot;
        int iter;
        logic [7:0] d_val;
        step();
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        cyc++;
        slot = (cyc - 1) % 33;
        iter = (cyc - 1) / 33;
        check_output("phase0",  32'(phase0),   32'(slot == 0));
        check_output("phase32", 32'(phase32),  32'(slot == 32));
        check_output("count",   32'(count),    32'(iter));
        check_output("enable",  32'(enable),   32'd1);
        check_output("busy",    32'(bus.busy), 32'd1);
        check_output("done",    32'(bus.done), 32'd0);
        if (slot == 15) begin
            if (di_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("[TB] FAIL di_queue observed=empty expected=entry at cycle %0d", cyc);
            end else begin
                di_cur = di_q.pop_front();
            end
        end
        check_output("DI", 32'(DI), 32'(di_cur));
        if (slot == 0) begin
            d_val = d_for(iter);
            D     = d_val;
            di_q.push_back(inv_model(d_val));
        end
    endtask

    initial begin
        clrn         = 1'b0;
        bus.start    = 1'b0;
        bus.syn_zero = 1'b0;
        bus.ack      = 1'b0;
        D            = 8'h00;
        di_cur       = 8'h01;

        // Reset and idle behaviour, stray ack ignored.
        repeat (3) step();
        check_reset_values("reset");
        clrn = 1'b1;
        step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        check_reset_values("idle_after_ack");

`ifdef RSDEC_BERL_CTRL_SKIP_EN
        // Syndrome-zero bypass: transition cycle with enable low, then HOLD.
        bus.start    = 1'b1;
        bus.syn_zero = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.syn_zero = 1'b0;
        check_output("skip_enable", 32'(enable),   32'd0);
        check_output("skip_busy",   32'(bus.busy), 32'd1);
        check_output("skip_done",   32'(bus.done), 32'd0);
        check_output("skip_p32",    32'(phase32),  32'd0);
        step();
        di_cur = 8'h01;
        check_hold("skip_hold");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check_output("skip_exit_busy", 32'(bus.busy), 32'd0);
        check_output("skip_exit_done", 32'(bus.done), 32'd0);
`endif

        // Full run, with stray start and ack pulses during RUN.
        apply_stimulus_start();
        for (int c = 1; c <= 1056; c++) begin
            run_cycle();
            if (c == 1 + 2 * 33 + 7)  bus.start = 1'b1;
            if (c == 1 + 10 * 33 + 5) bus.ack   = 1'b1;
            if (c == 1 + 3 * 33 + 15)
                check_output("field_02_x_DI", 32'(gf_mul_model(8'h02, DI)), 32'h01);
        end

        // HOLD: ack low for 50 cycles, a start here is ignored.
        step();
        check_hold("hold_entry");
        for (int h = 0; h < 50; h++) begin
            bus.start = (h == 10);
            step();
            check_hold("hold_wait");
        end
        bus.start = 1'b0;
        bus.ack   = 1'b1;
        step();
        bus.ack = 1'b0;
        check_output("exit_done",   32'(bus.done), 32'd0);
        check_output("exit_busy",   32'(bus.busy), 32'd0);
        check_output("exit_enable", 32'(enable),   32'd0);
        check_output("exit_phase0", 32'(phase0),   32'd0);

        // Second run accepted; reset at count=17, slot=20.
        apply_stimulus_start();
        for (int c = 1; c <= 1 + 17 * 33 + 20; c++) begin
            run_cycle();
        end
        check_output("pre_reset_count", 32'(count), 32'd17);
        clrn = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        clrn = 1'b1;
        di_q.delete();
        step();

        // Restart after reset begins again at count 0 with DI=1.
        apply_stimulus_start();
        for (int c = 1; c <= 3 * 33; c++) begin
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
